// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned HOLD_W          = 8;
    localparam int unsigned NUM_MASTERS     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT1    = 2'd1,
        GNT2    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Master index: also the value driven onto the bus mux select.
    typedef logic master_idx_t;

    localparam master_idx_t MST1 = 1'b0;
    localparam master_idx_t MST2 = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin choice between two masters.
module arb_rr_pick
    import bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] reqs,
    input  logic [NUM_MASTERS-1:0] elig,
    input  logic                   last_served,
    output logic                   valid,
    output logic                   winner
);

    logic [NUM_MASTERS-1:0] cand;

    // A lone candidate wins; on a tie the master not served last wins.
    always_comb begin
        cand   = reqs & elig;
        valid  = |cand;
        winner = MST1;
        case (cand)
            2'b01:   winner = MST1;
            2'b10:   winner = MST2;
            2'b11:   winner = (last_served == MST1) ? MST2 : MST1;
            default: winner = MST1;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin on ties, no pre-emption, a
// forced release after TIMEOUT grant cycles and a mandatory idle gap.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic m1_req,
    input  logic m2_req,
    output logic m1_grant,
    output logic m2_grant,
    output logic msel,
    output logic bus_busy,
    output logic timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);

    arb_state_e             state;
    arb_state_e             state_nxt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      hold_nxt;
    logic                   last_served;
    logic                   last_nxt;
    logic [NUM_MASTERS-1:0] inelig;
    logic [NUM_MASTERS-1:0] inelig_nxt;
    logic [NUM_MASTERS-1:0] reqs;
    logic                   msel_nxt;
    logic                   timeout_nxt;
    logic                   pick_valid;
    logic                   pick_winner;

    assign reqs = {m2_req, m1_req};

    arb_rr_pick u_pick (
        .reqs        (reqs),
        .elig        (~inelig),
        .last_served (last_served),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    // Next-state, hold counter, round-robin memory and lockout flags.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        last_nxt    = last_served;
        msel_nxt    = msel;
        timeout_nxt = 1'b0;
        inelig_nxt  = inelig & reqs;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = (pick_winner == MST2) ? GNT2 : GNT1;
                    hold_nxt  = '0;
                    last_nxt  = pick_winner;
                    msel_nxt  = pick_winner;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_nxt = RELEASE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = RELEASE;
                    timeout_nxt   = 1'b1;
                    inelig_nxt[0] = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            GNT2: begin
                if (!m2_req) begin
                    state_nxt = RELEASE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = RELEASE;
                    timeout_nxt   = 1'b1;
                    inelig_nxt[1] = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_served <= MST2;
            inelig      <= '0;
            m1_grant    <= 1'b0;
            m2_grant    <= 1'b0;
            msel        <= MST1;
            bus_busy    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            last_served <= last_nxt;
            inelig      <= inelig_nxt;
            m1_grant    <= (state_nxt == GNT1);
            m2_grant    <= (state_nxt == GNT2);
            msel        <= msel_nxt;
            bus_busy    <= (state_nxt == GNT1) || (state_nxt == GNT2);
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random
// request traffic compared against a transaction-level ownership model.
module tb_bus_arbiter;

    localparam int unsigned TO = 4;

    logic clk;
    logic rstn;
    logic m1_req;
    logic m2_req;
    logic m1_grant;
    logic m2_grant;
    logic msel;
    logic bus_busy;
    logic timeout;

    int n_checks;
    int n_errors;

    // Reference model: who owns the bus, for how long, and who is locked out.
    int mdl_owner;
    int mdl_held;
    int mdl_cool;
    int mdl_last;
    bit mdl_blk [1:2];
    bit mdl_msel;
    bit mdl_to;
    bit c1;
    bit c2;
    int win;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .m1_req   (m1_req),
        .m2_req   (m2_req),
        .m1_grant (m1_grant),
        .m2_grant (m2_grant),
        .msel     (msel),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit req_of(input int m);
        return (m == 1) ? m1_req : m2_req;
    endfunction

    task automatic model_reset();
        mdl_owner  = 0;
        mdl_held   = 0;
        mdl_cool   = 0;
        mdl_last   = 2;
        mdl_blk[1] = 1'b0;
        mdl_blk[2] = 1'b0;
        mdl_msel   = 1'b0;
        mdl_to     = 1'b0;
    endtask

    // One clock edge of bus ownership rules, using requests seen at the edge.
    task automatic model_edge();
        mdl_to = 1'b0;
        if (mdl_owner != 0) begin
            mdl_held++;
            if (!req_of(mdl_owner)) begin
                mdl_owner = 0;
                mdl_cool  = 1;
            end else if (mdl_held == int'(TO)) begin
                mdl_blk[mdl_owner] = 1'b1;
                mdl_to    = 1'b1;
                mdl_owner = 0;
                mdl_cool  = 1;
            end
        end else if (mdl_cool > 0) begin
            mdl_cool--;
        end else begin
            c1 = m1_req && !mdl_blk[1];
            c2 = m2_req && !mdl_blk[2];
            if (c1 || c2) begin
                if (c1 && c2) win = (mdl_last == 1) ? 2 : 1;
                else          win = c1 ? 1 : 2;
                mdl_owner = win;
                mdl_held  = 0;
                mdl_last  = win;
                mdl_msel  = (win == 2);
            end
        end
        if (!m1_req) mdl_blk[1] = 1'b0;
        if (!m2_req) mdl_blk[2] = 1'b0;
    endtask

    task automatic check_outputs();
        check("m1_grant", int'(m1_grant), int'(mdl_owner == 1));
        check("m2_grant", int'(m2_grant), int'(mdl_owner == 2));
        check("bus_busy", int'(bus_busy), int'(mdl_owner != 0));
        check("msel",     int'(msel),     int'(mdl_msel));
        check("timeout",  int'(timeout),  int'(mdl_to));
        check("grant_excl", int'(m1_grant & m2_grant), 0);
    endtask

    // Advance one clock; inputs stay stable across the edge, outputs sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        if (rstn) model_edge();
        else      model_reset();
        #2;
        check_outputs();
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        m1_req = 1'b0;
        m2_req = 1'b0;
        model_reset();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    int gcnt;
    int tcnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn     = 1'b0;
        m1_req   = 1'b0;
        m2_req   = 1'b0;
        model_reset();
        tick();
        tick();

        // Single request right after reset: grant one cycle later.
        rstn   = 1'b1;
        m1_req = 1'b1;
        tick();
        check("d1_m1_grant", int'(m1_grant), 1);
        check("d1_msel", int'(msel), 0);
        check("d1_busy", int'(bus_busy), 1);

        // Tie from reset goes to master 1; master 2 follows three cycles after the drop.
        do_reset();
        m1_req = 1'b1;
        m2_req = 1'b1;
        tick();
        check("d2_first_m1", int'(m1_grant), 1);
        tick();
        m1_req = 1'b0;
        tick();
        check("d2_release", int'(bus_busy), 0);
        tick();
        check("d2_idle_gap", int'(m2_grant), 0);
        tick();
        check("d2_m2_grant", int'(m2_grant), 1);
        check("d2_msel", int'(msel), 1);
        m2_req = 1'b0;
        tick();

        // Held request times out after TO grant cycles and is locked out.
        do_reset();
        m2_req = 1'b1;
        tick();
        gcnt = int'(m2_grant);
        tcnt = int'(timeout);
        for (int i = 0; i < 7; i++) begin
            tick();
            gcnt += int'(m2_grant);
            tcnt += int'(timeout);
        end
        check("d3_grant_cycles", gcnt, int'(TO));
        check("d3_timeout_pulses", tcnt, 1);
        check("d3_still_locked", int'(m2_grant), 0);
        m2_req = 1'b0;
        tick();
        m2_req = 1'b1;
        tick();
        check("d3_regrant", int'(m2_grant), 1);
        m2_req = 1'b0;
        tick();

        // No pre-emption while master 1 holds the bus.
        do_reset();
        m1_req = 1'b1;
        tick();
        m2_req = 1'b1;
        tick();
        check("d4_m1_holds", int'(m1_grant), 1);
        check("d4_no_preempt", int'(m2_grant), 0);
        m1_req = 1'b0;
        tick();
        tick();
        tick();
        check("d4_m2_after", int'(m2_grant), 1);

        // Asynchronous reset during a master 2 grant.
        do_reset();
        m2_req = 1'b1;
        tick();
        check("d5_m2_granted", int'(m2_grant), 1);
        rstn = 1'b0;
        #1;
        check("d5_async_m2_grant", int'(m2_grant), 0);
        check("d5_async_busy", int'(bus_busy), 0);
        model_reset();
        m1_req = 1'b1;
        m2_req = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        check("d5_m1_after_reset", int'(m1_grant), 1);

        // Request falls exactly when the hold count reaches its limit.
        do_reset();
        m1_req = 1'b1;
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        m1_req = 1'b0;
        tick();
        check("d6_no_timeout", int'(timeout), 0);
        check("d6_released", int'(m1_grant), 0);
        m1_req = 1'b1;
        tick();
        tick();
        tick();
        check("d6_not_locked", int'(m1_grant), 1);

        // Random request traffic with occasional asynchronous resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 399) == 0) begin
                rstn = 1'b0;
                #1;
                check("r_async_grants", int'(m1_grant | m2_grant), 0);
                model_reset();
                tick();
                rstn = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) m1_req = ~m1_req;
            if ($urandom_range(0, 4) == 0) m2_req = ~m2_req;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  TIMEOUT, 64, maximum consecutive grant cycles before forced release (range 2..255).
REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all state changes on its rising edge.
  rstn  input  1  reset, asynchronous and active-low.
  m1_req  input  1  master 1 requests the bus; held high for the whole transaction.
  m2_req  input  1  master 2 requests the bus; held high for the whole transaction.
  m1_grant  output  1  master 1 owns the bus.
  m2_grant  output  1  master 2 owns the bus.
  msel  output  1  bus mux select: 0 = master 1, 1 = master 2; stable while a grant is high.
  bus_busy  output  1  high whenever either grant is high.
  timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-003 The state machine SHALL have exactly the states IDLE, GNT1, GNT2 and RELEASE.
REQ-004 IDLE SHALL go to GNT1 or GNT2 when any req is high, chosen per REQ-006, and SHALL otherwise stay in IDLE.
REQ-005 All outputs SHALL be registered; grant rises in the cycle after the req is sampled in IDLE (latency 1).
REQ-006 Single req SHALL win; simultaneous reqs SHALL go to the master not served last (round-robin); the last_served register SHALL update on entry to GNT1/GNT2.
REQ-007 GNTx SHALL go to RELEASE in the cycle after m x_req is sampled low; the other master's req SHALL NOT pre-empt.
REQ-008 In RELEASE, both grants SHALL be low; RELEASE SHALL always go to IDLE after one cycle.
REQ-009 The minimum gap between one grant falling and any grant rising SHALL be 2 cycles (RELEASE, then IDLE).
REQ-010 An 8-bit hold counter SHALL clear on entry to GNTx and increment each GNTx cycle.
REQ-011 When the hold counter equals TIMEOUT-1 and req is still high, the FSM SHALL go to RELEASE, and timeout SHALL be high for exactly that RELEASE cycle.
REQ-012 After a timeout, the offending master SHALL be ineligible until its req has been sampled low at least once.
REQ-013 If req falls in the same cycle the timeout condition is reached, the release SHALL be normal and timeout SHALL stay low.
REQ-014 m1_grant and m2_grant SHALL never both be high.
REQ-015 msel SHALL hold its value through RELEASE and IDLE, and change only on entry to a GNT state.
REQ-016 Req pulses seen only during RELEASE SHALL be ignored; arbitration SHALL sample only in IDLE.

Reset
REQ-017 While rstn is low, the state SHALL be IDLE and grants, bus_busy, timeout, msel and the hold counter SHALL all be 0.
REQ-018 While rstn is low, last_served SHALL be master 2 so that master 1 wins the first tie, and both ineligible flags SHALL be clear.
REQ-019 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), with no RELEASE cycle.
REQ-020 After reset deassertion, the first grant SHALL occur at the earliest 1 cycle after a req is sampled.

Structure
REQ-021 Package bus_pkg SHALL hold the arbiter state enum (2-bit), the master-index type and the default TIMEOUT constant.
REQ-022 A sub-module arb_rr_pick SHALL provide the combinational round-robin choice (inputs: reqs, eligibility, last_served; outputs: valid, winner).

Verification
REQ-023 The bench SHALL cover: m1_req high at cycle 0 -> m1_grant=1, msel=0, bus_busy=1 at cycle 1.
REQ-024 The bench SHALL cover: both reqs high from reset -> GNT1 first; m1_req drops -> RELEASE, IDLE, then m2_grant=1 three cycles after the drop.
REQ-025 The bench SHALL cover: TIMEOUT=4, m2_req held high -> m2_grant high for 4 cycles, timeout pulses once, and m2 is not regranted until m2_req toggles low.
REQ-026 The bench SHALL cover: m1 holding grant while m2_req rises -> no pre-emption, and m2_grant only after m1 releases.
REQ-027 The bench SHALL cover: rstn low during GNT2 -> m2_grant=0 in the same cycle; after rstn release with both reqs high -> master 1 granted.
REQ-028 The bench SHALL cover: req fall coinciding with the timeout count -> timeout stays 0.
